// File: rtl/irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : irq_pkg                                                     |
// | Brief  : Shared sizes and state encoding for the interrupt controller|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package irq_pkg;

   localparam int N_IRQ = 32;
   localparam int ID_W  = 5;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PEND = 3'd1,
      SERV = 3'd2,
      FIN  = 3'd3,
      HOLD = 3'd4
   } irq_state_t;

   // Plain-vector aliases of the state encoding for the state register
   localparam logic [2:0] S_IDLE = IDLE;
   localparam logic [2:0] S_PEND = PEND;
   localparam logic [2:0] S_SERV = SERV;
   localparam logic [2:0] S_FIN  = FIN;
   localparam logic [2:0] S_HOLD = HOLD;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_arbiter                                                  |
// | Brief  : Combinational round-robin pick: first set request at or     |
// |          above ptr, wrapping from the top source back to source 0.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
   import irq_pkg::*;
(
   input  logic [N_IRQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             gnt_valid,
   output logic [ID_W-1:0]  gnt_id
);

   logic [N_IRQ-1:0] w_rot;
   logic [ID_W-1:0]  w_off;

   // Rotate so that source ptr lands on bit 0; the doubled vector makes the wrap free
   assign w_rot = N_IRQ'({req, req} >> ptr);

   // Priority encode the lowest set bit of the rotated vector
   always_comb begin
      w_off = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = ID_W'(i);
         end
      end
   end

   assign gnt_valid = |req;
   // Undo the rotation; ID_W-bit addition wraps modulo N_IRQ
   assign gnt_id    = ptr + w_off;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : irq_ctrl                                                    |
// | Brief  : Masks 32 level interrupt lines, presents one source to the  |
// |          core by round-robin and returns a fin pulse on mret.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module irq_ctrl #(
   parameter int N_IRQ = irq_pkg::N_IRQ,
   parameter int ID_W  = irq_pkg::ID_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] dev_int_req,
   output logic [N_IRQ-1:0] dev_int_fin,
   input  logic [N_IRQ-1:0] irq_mask_i,
   output logic             irq_o,
   output logic [ID_W-1:0]  irq_id_o,
   input  logic             irq_ack_i,
   input  logic             irq_ret_i
);

   import irq_pkg::*;

   logic [2:0]       r_state;
   logic [ID_W-1:0]  r_rr_ptr;
   logic [ID_W-1:0]  r_irq_id;
   logic [N_IRQ-1:0] r_fin;

   logic [N_IRQ-1:0] w_elig;
   logic             w_gnt_valid;
   logic [ID_W-1:0]  w_gnt_id;

   assign w_elig = dev_int_req & irq_mask_i;

   rr_arbiter u_arb (
      .req       (w_elig),
      .ptr       (r_rr_ptr),
      .gnt_valid (w_gnt_valid),
      .gnt_id    (w_gnt_id)
   );

   // Control FSM: latch winner, hand off to core, pulse fin, then rest one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_irq_id <= '0;
         r_fin    <= '0;
      end else begin
         r_fin <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_gnt_valid) begin
                  r_irq_id <= w_gnt_id;
                  r_state  <= S_PEND;
               end
            end
            S_PEND: begin
               // Ack takes precedence over a simultaneous withdrawal
               if (irq_ack_i) begin
                  r_state <= S_SERV;
               end else if (!w_elig[r_irq_id]) begin
                  r_state <= S_IDLE;
               end
            end
            S_SERV: begin
               if (irq_ret_i) begin
                  r_fin   <= N_IRQ'(1) << r_irq_id;
                  r_state <= S_FIN;
               end
            end
            S_FIN: begin
               // Next search starts just after the source that was serviced
               r_rr_ptr <= r_irq_id + ID_W'(1);
               r_state  <= S_HOLD;
            end
            S_HOLD: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign irq_o       = (r_state == S_PEND);
   assign irq_id_o    = r_irq_id;
   assign dev_int_fin = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_irq_ctrl                                                 |
// | Brief  : Self-checking bench for irq_ctrl against a round-robin      |
// |          reference model                                             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dev_int_req;
   logic [31:0] dev_int_fin;
   logic [31:0] irq_mask_i;
   logic        irq_o;
   logic [4:0]  irq_id_o;
   logic        irq_ack_i;
   logic        irq_ret_i;

   int n_checks = 0;
   int n_fail   = 0;
   int m_ptr    = 0;   // reference round-robin start position

   irq_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .dev_int_req (dev_int_req),
      .dev_int_fin (dev_int_fin),
      .irq_mask_i  (irq_mask_i),
      .irq_o       (irq_o),
      .irq_id_o    (irq_id_o),
      .irq_ack_i   (irq_ack_i),
      .irq_ret_i   (irq_ret_i)
   );

   always #5 clk = ~clk;

   // Advance one clock and land 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: first eligible source searching upward from ptr with wrap
   function automatic int rr_pick(input logic [31:0] elig, input int ptr);
      for (int k = 0; k < 32; k++) begin
         int idx;
         idx = (ptr + k) % 32;
         if (elig[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_ptr = 0;
   endtask

   // Ack now, ret after gap cycles, expect fin for exp_id, device drops 'drop' lines
   task automatic do_service(input int exp_id, input int gap, input logic [31:0] drop);
      logic [31:0] exp_fin;
      exp_fin = 32'd1 << exp_id;
      n_checks++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'(exp_id)) begin
         n_fail++;
         $display("FAIL svc_present: irq_o=%0b id=%0d expected irq_o=1 id=%0d", irq_o, irq_id_o, exp_id);
      end
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      n_checks++;
      if (irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL svc_ack_drop: irq_o=%0b expected 0", irq_o);
      end
      for (int g = 0; g < gap; g++) begin
         tick();
         n_checks++;
         if (dev_int_fin !== 32'd0 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL svc_wait: fin=%h irq_o=%0b expected fin=0 irq_o=0", dev_int_fin, irq_o);
         end
      end
      irq_ret_i = 1'b1;
      tick();
      irq_ret_i = 1'b0;
      n_checks++;
      if (dev_int_fin !== exp_fin || irq_id_o !== 5'(exp_id)) begin
         n_fail++;
         $display("FAIL svc_fin: fin=%h id=%0d expected fin=%h id=%0d", dev_int_fin, irq_id_o, exp_fin, exp_id);
      end
      dev_int_req = dev_int_req & ~drop;
      tick();
      n_checks++;
      if (dev_int_fin !== 32'd0 || irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL svc_hold: fin=%h irq_o=%0b expected fin=0 irq_o=0", dev_int_fin, irq_o);
      end
      tick();
      n_checks++;
      if (dev_int_fin !== 32'd0 || irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL svc_idle: fin=%h irq_o=%0b expected fin=0 irq_o=0", dev_int_fin, irq_o);
      end
      m_ptr = (exp_id + 1) % 32;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dev_int_req = 32'hFFFF_FFFF;
      irq_mask_i  = 32'hFFFF_FFFF;
      tick();
      tick();
      n_checks++;
      if (irq_o !== 1'b0 || irq_id_o !== 5'd0 || dev_int_fin !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_vals: irq_o=%0b id=%0d fin=%h expected 0/0/0", irq_o, irq_id_o, dev_int_fin);
      end
      dev_int_req = 32'd0;
      rst = 1'b0;
      m_ptr = 0;
      tick();
      n_checks++;
      if (irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: irq_o=%0b expected 0", irq_o);
      end
   endtask

   task automatic test_single();
      do_reset();
      dev_int_req[7] = 1'b1;
      tick();
      n_checks++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'd7) begin
         n_fail++;
         $display("FAIL single_latency: irq_o=%0b id=%0d expected 1/7", irq_o, irq_id_o);
      end
      do_service(7, 5, 32'h0000_0080);
   endtask

   task automatic test_round_robin();
      int order [4] = '{3, 20, 3, 20};
      do_reset();
      dev_int_req = 32'h0010_0008;
      for (int s = 0; s < 4; s++) begin
         int exp;
         tick();
         exp = rr_pick(dev_int_req & irq_mask_i, m_ptr);
         n_checks++;
         if (exp != order[s] || irq_o !== 1'b1 || irq_id_o !== 5'(order[s])) begin
            n_fail++;
            $display("FAIL rr_order: step %0d irq_o=%0b id=%0d expected id=%0d", s, irq_o, irq_id_o, order[s]);
         end
         do_service(order[s], s, 32'd0);
      end
      dev_int_req = 32'd0;
      tick();
   endtask

   task automatic test_masking();
      do_reset();
      irq_mask_i  = 32'hFFFF_FDFF;
      dev_int_req = 32'h0000_0200;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++;
         if (irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_blocked: cycle %0d irq_o=%0b expected 0", c, irq_o);
         end
      end
      irq_mask_i = 32'hFFFF_FFFF;
      tick();
      n_checks++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'd9) begin
         n_fail++;
         $display("FAIL mask_enable: irq_o=%0b id=%0d expected 1/9", irq_o, irq_id_o);
      end
      irq_mask_i[9] = 1'b0;
      tick();
      n_checks++;
      if (irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mask_withdraw: irq_o=%0b expected 0", irq_o);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (irq_o !== 1'b0 || dev_int_fin !== 32'd0) begin
            n_fail++;
            $display("FAIL mask_no_fin: irq_o=%0b fin=%h expected 0/0", irq_o, dev_int_fin);
         end
      end
      // Withdrawal kept the pointer, so 9 is picked again
      irq_mask_i[9] = 1'b1;
      tick();
      n_checks++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'd9) begin
         n_fail++;
         $display("FAIL mask_repend: irq_o=%0b id=%0d expected 1/9", irq_o, irq_id_o);
      end
      irq_mask_i[9] = 1'b0;
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      irq_ret_i = 1'b1;
      tick();
      irq_ret_i = 1'b0;
      n_checks++;
      if (dev_int_fin !== 32'h0000_0200) begin
         n_fail++;
         $display("FAIL mask_ack_wins: fin=%h expected 00000200", dev_int_fin);
      end
      m_ptr = 10;
      dev_int_req = 32'd0;
      irq_mask_i  = 32'hFFFF_FFFF;
      tick();
      tick();
   endtask

   task automatic test_stray();
      do_reset();
      irq_ret_i = 1'b1;
      tick();
      irq_ret_i = 1'b0;
      n_checks++;
      if (irq_o !== 1'b0 || dev_int_fin !== 32'd0) begin
         n_fail++;
         $display("FAIL stray_ret_idle: irq_o=%0b fin=%h expected 0/0", irq_o, dev_int_fin);
      end
      dev_int_req[4] = 1'b1;
      tick();
      irq_ret_i = 1'b1;
      tick();
      irq_ret_i = 1'b0;
      n_checks++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'd4 || dev_int_fin !== 32'd0) begin
         n_fail++;
         $display("FAIL stray_ret_pend: irq_o=%0b id=%0d fin=%h expected 1/4/0", irq_o, irq_id_o, dev_int_fin);
      end
      irq_ack_i = 1'b1;
      tick();
      tick();
      irq_ack_i = 1'b0;
      n_checks++;
      if (irq_o !== 1'b0 || dev_int_fin !== 32'd0) begin
         n_fail++;
         $display("FAIL stray_ack_serv: irq_o=%0b fin=%h expected 0/0", irq_o, dev_int_fin);
      end
      irq_ret_i = 1'b1;
      tick();
      irq_ret_i = 1'b0;
      n_checks++;
      if (dev_int_fin !== 32'h0000_0010) begin
         n_fail++;
         $display("FAIL stray_fin: fin=%h expected 00000010", dev_int_fin);
      end
      dev_int_req = 32'd0;
      m_ptr = 5;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_service();
      do_reset();
      dev_int_req[12] = 1'b1;
      tick();
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_ptr = 0;
      n_checks++;
      if (irq_o !== 1'b0 || irq_id_o !== 5'd0 || dev_int_fin !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: irq_o=%0b id=%0d fin=%h expected 0/0/0", irq_o, irq_id_o, dev_int_fin);
      end
      tick();
      n_checks++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'd12 || dev_int_fin !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_mid_represent: irq_o=%0b id=%0d fin=%h expected 1/12/0", irq_o, irq_id_o, dev_int_fin);
      end
      do_service(12, 1, 32'h0000_1000);
   endtask

   task automatic test_wrap();
      do_reset();
      dev_int_req[31] = 1'b1;
      tick();
      do_service(31, 0, 32'h8000_0000);
      dev_int_req = 32'h4000_0001;
      tick();
      n_checks++;
      if (m_ptr != 0 || irq_o !== 1'b1 || irq_id_o !== 5'd0) begin
         n_fail++;
         $display("FAIL wrap_first: irq_o=%0b id=%0d expected 1/0", irq_o, irq_id_o);
      end
      do_service(0, 2, 32'h0000_0001);
      tick();
      n_checks++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'd30) begin
         n_fail++;
         $display("FAIL wrap_second: irq_o=%0b id=%0d expected 1/30", irq_o, irq_id_o);
      end
      do_service(30, 0, 32'h4000_0000);
   endtask

   task automatic test_random();
      do_reset();
      for (int it = 0; it < 40; it++) begin
         logic [31:0] req;
         logic [31:0] msk;
         int          exp;
         req = $urandom;
         msk = $urandom | $urandom;
         if ((req & msk) == 32'd0) req[$urandom_range(31, 0)] = 1'b1;
         if ((req & msk) == 32'd0) msk = 32'hFFFF_FFFF;
         dev_int_req = req;
         irq_mask_i  = msk;
         tick();
         exp = rr_pick(req & msk, m_ptr);
         n_checks++;
         if (irq_o !== 1'b1 || irq_id_o !== 5'(exp)) begin
            n_fail++;
            $display("FAIL rand_pick: iter %0d id=%0d irq_o=%0b expected id=%0d", it, irq_id_o, irq_o, exp);
         end
         // Occasionally withdraw the winner by masking it before the ack
         if ($urandom_range(3, 0) == 0) begin
            irq_mask_i[exp] = 1'b0;
            tick();
            n_checks++;
            if (irq_o !== 1'b0 || dev_int_fin !== 32'd0) begin
               n_fail++;
               $display("FAIL rand_withdraw: iter %0d irq_o=%0b fin=%h expected 0/0", it, irq_o, dev_int_fin);
            end
            if ((dev_int_req & irq_mask_i) == 32'd0) begin
               dev_int_req = 32'd0;
               irq_mask_i  = 32'hFFFF_FFFF;
               tick();
               continue;
            end
            tick();
            exp = rr_pick(dev_int_req & irq_mask_i, m_ptr);
         end
         do_service(exp, $urandom_range(3, 0), 32'hFFFF_FFFF);
      end
   endtask

   initial begin
      rst         = 1'b1;
      dev_int_req = 32'd0;
      irq_mask_i  = 32'hFFFF_FFFF;
      irq_ack_i   = 1'b0;
      irq_ret_i   = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_masking();
      test_stray();
      test_reset_mid_service();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
